// File: rtl/free_list.sv
// Physical-register free list for an R10000-style rename stage: circular tag FIFO
// with per-ROB-entry head checkpoints for single-cycle branch rollback.
module free_list #(
  parameter int NUM_PR   = 64,
  parameter int NUM_ARCH = 32,
  parameter int NUM_ROB  = 8,
  parameter int ZERO_PR  = 31,
  localparam int PR_W     = $clog2(NUM_PR),
  localparam int FL_DEPTH = NUM_PR - NUM_ARCH,
  localparam int ROB_W    = $clog2(NUM_ROB),
  localparam int CNT_W    = $clog2(FL_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             dispatch_en,
  input  logic [4:0]       dest_idx,
  input  logic [ROB_W-1:0] ROB_tail_idx,
  input  logic             retire_en,
  input  logic [PR_W-1:0]  Told_idx,
  input  logic             rollback_en,
  input  logic [ROB_W-1:0] ROB_rollback_idx,
  output logic [PR_W-1:0]  T_idx,
  output logic             free_valid,
  output logic [CNT_W-1:0] free_count
);

  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PR_W-1:0]  fl_q   [FL_DEPTH];
  logic [PTR_W-1:0] ckpt_q [NUM_ROB];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] head_after_pop;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             pop, push, ckpt_wr, full;

  // Index wraps at FL_DEPTH-1 and toggles the wrap bit, so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == IDX_W'(FL_DEPTH - 1))
      ptr_inc = {~p[PTR_W-1], {IDX_W{1'b0}}};
    else
      ptr_inc = p + PTR_W'(1);
  endfunction

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  always_comb begin
    if (head_q[PTR_W-1] == tail_q[PTR_W-1])
      free_count = CNT_W'(tail_idx) - CNT_W'(head_idx);
    else
      free_count = CNT_W'(FL_DEPTH) - CNT_W'(head_idx) + CNT_W'(tail_idx);
  end

  assign free_valid = (free_count != '0);
  assign full       = (free_count == CNT_W'(FL_DEPTH));
  assign T_idx      = fl_q[head_idx];

  assign pop     = dispatch_en && (dest_idx != 5'd31) && free_valid && !rollback_en;
  // A push into a full list is dropped unless a same-cycle pop makes room.
  assign push    = retire_en && (Told_idx != PR_W'(ZERO_PR)) && !(full && !pop);
  assign ckpt_wr = dispatch_en && !rollback_en;

  assign head_after_pop = pop ? ptr_inc(head_q) : head_q;

  always_comb begin
    head_d = head_after_pop;
    tail_d = tail_q;
    if (rollback_en)
      head_d = ckpt_q[ROB_rollback_idx];
    if (push)
      tail_d = ptr_inc(tail_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= PTR_W'(FL_DEPTH);
      for (int k = 0; k < FL_DEPTH; k++)
        fl_q[k] <= PR_W'(NUM_ARCH + k);
      for (int k = 0; k < NUM_ROB; k++)
        ckpt_q[k] <= '0;
    end else if (en) begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (push)
        fl_q[tail_idx] <= Told_idx;
      if (ckpt_wr)
        ckpt_q[ROB_tail_idx] <= head_after_pop;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset values, exhaustion, push/pop interplay,
// checkpoint rollback, pointer wrap with a FIFO model, stall and mid-run reset.
module tb_free_list;

  logic       clock;
  logic       reset;
  logic       en;
  logic       dispatch_en;
  logic [4:0] dest_idx;
  logic [2:0] ROB_tail_idx;
  logic       retire_en;
  logic [5:0] Told_idx;
  logic       rollback_en;
  logic [2:0] ROB_rollback_idx;
  logic [5:0] T_idx;
  logic       free_valid;
  logic [5:0] free_count;

  int err_cnt = 0;
  int chk_cnt = 0;
  int txn_cnt = 0;
  int q[$];

  free_list dut (
    .clock           (clock),
    .reset           (reset),
    .en              (en),
    .dispatch_en     (dispatch_en),
    .dest_idx        (dest_idx),
    .ROB_tail_idx    (ROB_tail_idx),
    .retire_en       (retire_en),
    .Told_idx        (Told_idx),
    .rollback_en     (rollback_en),
    .ROB_rollback_idx(ROB_rollback_idx),
    .T_idx           (T_idx),
    .free_valid      (free_valid),
    .free_count      (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    dispatch_en      = 1'b0;
    dest_idx         = 5'd0;
    ROB_tail_idx     = 3'd0;
    retire_en        = 1'b0;
    Told_idx         = 6'd0;
    rollback_en      = 1'b0;
    ROB_rollback_idx = 3'd0;
  endtask

  // One clock with the given stimulus; outputs are sampled 1ns after the edge.
  task automatic cycle(input logic d, input logic [4:0] dst, input logic [2:0] slot,
                       input logic r, input logic [5:0] told,
                       input logic rb, input logic [2:0] rbi);
    dispatch_en      = d;
    dest_idx         = dst;
    ROB_tail_idx     = slot;
    retire_en        = r;
    Told_idx         = told;
    rollback_en      = rb;
    ROB_rollback_idx = rbi;
    @(posedge clock);
    #1;
    txn_cnt++;
    $display("txn %0d: rst=%0b en=%0b disp=%0b dst=%0d slot=%0d ret=%0b told=%0d rb=%0b rbi=%0d -> T_idx=%0d valid=%0b count=%0d",
             txn_cnt, reset, en, d, dst, slot, r, told, rb, rbi, T_idx, free_valid, free_count);
    idle();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_T_idx"}, T_idx, 32);
    check({tag, "_valid"}, free_valid, 1);
    check({tag, "_count"}, free_count, 32);
  endtask

  initial begin
    idle();
    en    = 1'b1;
    reset = 1'b0;
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    check_reset_state("reset");

    // No-allocate destination and zero-tag retire leave the list untouched.
    cycle(1, 31, 0, 0, 0, 0, 0);
    check("dest31_T", T_idx, 32);
    check("dest31_count", free_count, 32);
    cycle(0, 0, 0, 1, 31, 0, 0);
    check("told31_T", T_idx, 32);
    check("told31_count", free_count, 32);
    // Push into a full list is dropped and must not overwrite the head entry.
    cycle(0, 0, 0, 1, 5, 0, 0);
    check("overflow_T", T_idx, 32);
    check("overflow_count", free_count, 32);

    // Rollback to a never-written slot restores the reset checkpoint of 0.
    cycle(1, 1, 1, 0, 0, 0, 0);
    check("pop1_T", T_idx, 33);
    check("pop1_count", free_count, 31);
    cycle(0, 0, 0, 0, 0, 1, 7);
    check("rb_reset_ckpt_T", T_idx, 32);
    check("rb_reset_ckpt_count", free_count, 32);

    // Drain all 32 tags in order.
    for (int i = 0; i < 32; i++) begin
      check("drain_T", T_idx, 32 + i);
      cycle(1, 1, 3'(i % 8), 0, 0, 0, 0);
    end
    check("empty_valid", free_valid, 0);
    check("empty_count", free_count, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    check("empty_disp_T", T_idx, 32);
    check("empty_disp_count", free_count, 0);
    check("empty_disp_valid", free_valid, 0);

    // Retire into an empty list alongside a dispatch: no pop, tag visible next cycle.
    cycle(1, 1, 0, 1, 5, 0, 0);
    check("refill_T", T_idx, 5);
    check("refill_count", free_count, 1);
    check("refill_valid", free_valid, 1);

    reset = 1'b0;
    cycle(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    check_reset_state("reset2");

    // Checkpoint rollback.
    cycle(1, 1, 2, 0, 0, 0, 0);
    check("ck_slot2_T", T_idx, 33);
    cycle(1, 1, 3, 0, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0, 0);
    check("ck_slot4_T", T_idx, 35);
    check("ck_slot4_count", free_count, 29);
    cycle(0, 0, 0, 0, 0, 1, 2);
    check("rb2_T", T_idx, 33);
    check("rb2_count", free_count, 31);

    cycle(1, 1, 5, 0, 0, 0, 0);
    cycle(1, 1, 6, 0, 0, 0, 0);
    check("ck_slot6_T", T_idx, 35);
    check("ck_slot6_count", free_count, 29);
    // Rollback + retire + ignored dispatch in one cycle.
    cycle(1, 1, 5, 1, 7, 1, 5);
    check("rb_ret_T", T_idx, 34);
    check("rb_ret_count", free_count, 31);
    // The ignored dispatch must not have rewritten slot 5's checkpoint.
    cycle(0, 0, 0, 0, 0, 1, 5);
    check("rb_again_T", T_idx, 34);
    check("rb_again_count", free_count, 31);
    for (int i = 0; i < 30; i++) begin
      check("walk_T", T_idx, 34 + i);
      cycle(1, 1, 0, 0, 0, 0, 0);
    end
    check("pushed7_T", T_idx, 7);
    check("pushed7_count", free_count, 1);

    // Stall holds everything, including rollback.
    en = 1'b0;
    cycle(1, 1, 0, 1, 9, 0, 0);
    check("hold1_T", T_idx, 7);
    check("hold1_count", free_count, 1);
    cycle(0, 0, 0, 0, 0, 1, 2);
    check("hold2_T", T_idx, 7);
    check("hold2_count", free_count, 1);
    check("hold2_valid", free_valid, 1);
    // Reset wins over stall and over pending activity.
    reset = 1'b0;
    cycle(1, 1, 0, 1, 9, 0, 0);
    reset = 1'b1;
    en    = 1'b1;
    check_reset_state("reset_mid");

    // Alternate alloc/free 100 times; pointers wrap three times.
    q.delete();
    for (int k = 0; k < 32; k++) q.push_back(32 + k);
    for (int i = 0; i < 100; i++) begin
      int exp_t;
      int told;
      exp_t = q.pop_front();
      check("wrap_T", T_idx, exp_t);
      cycle(1, 1, 3'(i % 8), 0, 0, 0, 0);
      check("wrap_pop_count", free_count, 31);
      told = (i * 7 + 3) % 31;
      q.push_back(told);
      cycle(0, 0, 0, 1, 6'(told), 0, 0);
      check("wrap_push_count", free_count, 32);
    end
    check("wrap_end_T", T_idx, q[0]);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
